// File: rtl/multu_hilo.sv
// rtl/multu_hilo.sv - multi-cycle shift-add unsigned multiplier with Hi/Lo registers
//
// Purpose:
//   Executes MULTU one partial product per clock and holds the architectural
//   Hi/Lo registers read back by MFHI/MFLO through the writeback result mux.
//   Hi/Lo change only when a product completes, so reads issued during an
//   iteration return the previous product.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   reset   in   1      asynchronous active-low reset
//   start   in   1      request qualifier from control
//   Signal  in   6      funct field; MULTU starts a multiply
//   dataA   in   WIDTH  multiplicand (rs)
//   dataB   in   WIDTH  multiplier (rt)
//   busy    out  1      high while iterating (state RUN)
//   done    out  1      one-cycle pulse when Hi/Lo take a new product
//   HiOut   out  WIDTH  upper half of the last product
//   LoOut   out  WIDTH  lower half of the last product

module multu_hilo #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'b011001,
    parameter int          CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [2*WIDTH:0]   prod;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   counter;

    logic               accept;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   next_prod;

    // A new multiply may begin from IDLE or straight out of DONE; requests
    // during RUN are dropped and control is expected to stall on busy.
    assign accept = start && (Signal == MULTU) && (state != RUN);

    // One shift-add step. The upper field is WIDTH+1 bits wide so the carry
    // out of the add survives and is shifted down into bit 2*WIDTH-1.
    always_comb begin
        upper_sum = prod[2*WIDTH:WIDTH];
        if (prod[0]) begin
            upper_sum = prod[2*WIDTH:WIDTH] + {1'b0, mcand};
        end
        next_prod = {1'b0, upper_sum, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            prod    <= '0;
            mcand   <= '0;
            counter <= '0;
            HiOut   <= '0;
            LoOut   <= '0;
        end else if (state == RUN) begin
            prod    <= next_prod;
            counter <= counter + 1'b1;
            if (counter == LAST_ITER) begin
                HiOut <= next_prod[2*WIDTH-1:WIDTH];
                LoOut <= next_prod[WIDTH-1:0];
                state <= DONE;
            end
        end else if (accept) begin
            mcand   <= dataA;
            prod    <= {{(WIDTH+1){1'b0}}, dataB};
            counter <= '0;
            state   <= RUN;
        end else begin
            state <= IDLE;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
